fsm_calibration_phase_multi: RTL
================================

# fsm_calibration_phase_multi

Parametrised, multi-channel successor of the single-channel calibration-phase sequencer in the synchronization block. After a start edge it waits for the frame-grabber opto front and the shutter-open delay. It then fires on successive phase fronts, running a burst of one or more cycles. In each cycle every enabled channel emits one trigger pulse with its own phase shift and length. It adds abort, a wait timeout, burst repetition and busy/done status.

## Interface
- NUM_CH, 4: number of trigger output channels (1..16)
- CNT_W, 32: width of all delay/length counters and runtime parameters
- BURST_W, 8: width of burst count and burst index
- SYNC_STAGES, 2: synchronizer flops on each asynchronous input (>=2)

- clock  in  1  single system clock; all logic on rising edge
- reset_signal  in  1  asynchronous, active-low reset
- start_signal  in  1  async; rising edge starts a scenario from IDLE
- abort_signal  in  1  async; rising edge returns to IDLE from any state
- fg_signal  in  1  async frame-grabber opto signal
- phase_signal  in  1  async phase reference
- fg_open_delay  in  CNT_W  cycles between fg front and phase arming
- fg_timeout  in  CNT_W  max cycles waiting for fg or phase front; 0 = disabled
- burst_count  in  BURST_W  phase cycles per scenario; 0 treated as 1
- ch_enable  in  NUM_CH  per-channel enable
- ch_phase_shift  in  NUM_CH*CNT_W  per-channel delay; channel i at [i*CNT_W +: CNT_W]
- ch_trigger_len  in  NUM_CH*CNT_W  per-channel pulse length, same packing
- output_trigger  out  NUM_CH  registered trigger pulses
- busy  out  1  high in every state except IDLE
- done  out  1  one-cycle pulse on normal scenario completion
- timeout_err  out  1  sticky; set on timeout, cleared by next accepted start
- burst_index  out  BURST_W  number of completed phase cycles in current scenario
- scenario_state  out  8  zero-extended state code

## Operation
- Inputs: SYNC_STAGES-flop synchronizer, then a one-flop rising-edge detector per input.
- State codes: IDLE=0, FG_WAIT_OPTO=1, FG_WAIT_OPEN=2, WAIT_PHASE_FRONT=3, FIRE=4, DONE=5. Any other code goes to IDLE.
- IDLE -> FG_WAIT_OPTO on start edge. On this transition:
  - latch all runtime parameter inputs; later input changes do not affect the running scenario
  - clear burst_index, clear timeout_err
- FG_WAIT_OPTO -> FG_WAIT_OPEN on fg edge; the wait counter is cleared.
- FG_WAIT_OPEN: count fg_open_delay cycles, then go to WAIT_PHASE_FRONT. Phase edges in this state are ignored.
- WAIT_PHASE_FRONT -> FIRE on phase edge; every enabled channel loads its shift/length counter.
- FIRE: channel i output rules
  - goes high after shift S_i cycles and stays high L_i cycles
  - L_i=0 or disabled: no pulse
  - phase edges are ignored, not queued
- FIRE exit: when all enabled channels have finished (immediately if none are enabled or all L are 0), increment burst_index.
  - if burst_index < effective burst_count -> WAIT_PHASE_FRONT
  - else -> DONE
- DONE: assert done for one cycle, then go to IDLE.
- Timeout applies in FG_WAIT_OPTO and WAIT_PHASE_FRONT when fg_timeout != 0:
  - when the wait counter reaches fg_timeout -> IDLE, timeout_err=1
  - no done pulse
- Abort edge in any non-IDLE state:
  - next state IDLE, all output_trigger low next cycle, no done
  - timeout_err unchanged
  - abort has priority over every other event in the same cycle
- Start edge outside IDLE: ignored. Abort edge in IDLE: no effect.
- Counters are CNT_W unsigned, compared with >=; they never wrap. burst_index saturates at 2^BURST_W-1.

## Timing
- Reset (asynchronous, while reset_signal=0):
  - state IDLE; output_trigger, busy, done, timeout_err, burst_index all 0; scenario_state 0
  - synchronizer and edge flops 0, so a level high at reset release does not produce an edge
- Edge latency: the edge flag is high in the cycle after the last synchronizer stage first samples 1. The state changes at the next clock.
- Let cycle t be the cycle the phase edge flag is high (state WAIT_PHASE_FRONT). Then:
  - output_trigger[i] is high in cycles t+1+S_i through t+S_i+L_i inclusive
  - S_i=0 gives a high output in cycle t+1
- FIRE ends in the cycle after the last channel's final high cycle. The next state (WAIT_PHASE_FRONT or DONE) is visible one cycle later.
- FG_WAIT_OPEN lasts exactly fg_open_delay+1 cycles (delay 0 = 1 cycle).
- done is high exactly one cycle, while scenario_state=5. busy is 0 in the following cycle.
- Timeout: fg_timeout=T means the transition to IDLE occurs T cycles after entering the wait state.

## Test plan
- NUM_CH=4, all enabled, fg_open_delay=10, shifts {0,5,20,3}, lens {4,1,8,0}, burst_count=1; start, fg, phase -> ch0 high t+1..t+4, ch1 t+6, ch2 t+21..t+28, ch3 never; done once; burst_index=1.
- burst_count=3, three phase fronts 200 cycles apart plus one extra front during FIRE -> exactly 3 pulse groups, extra front ignored, burst_index=3, single done.
- fg_timeout=50, no fg edge -> IDLE 50 cycles after entering FG_WAIT_OPTO, timeout_err=1, no done; next start clears timeout_err.
- Abort mid-pulse on ch2 -> all outputs low next cycle, state 0, busy 0, no done; a new start then runs normally.
- Reset asserted during FIRE, released with start_signal held high -> all outputs 0 immediately, no start edge detected until the signal falls and rises.
- ch_enable=0, burst_count=0 -> after the phase front, FIRE exits immediately, done pulses, no triggers, burst_index=1.

Source files
------------

// File: rtl/fsm_calibration_phase_multi.sv
// Multi-channel calibration-phase sequencer. After a start edge it waits for
// the frame-grabber opto front and the shutter-open delay. It then fires a
// burst of phase-triggered cycles. In each cycle every enabled channel emits
// one pulse with its own shift and length. Abort, wait timeout and
// busy/done status are included.
module fsm_calibration_phase_multi #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int BURST_W     = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                    clock,
  input  logic                    reset_signal,
  input  logic                    start_signal,
  input  logic                    abort_signal,
  input  logic                    fg_signal,
  input  logic                    phase_signal,
  input  logic [CNT_W-1:0]        fg_open_delay,
  input  logic [CNT_W-1:0]        fg_timeout,
  input  logic [BURST_W-1:0]      burst_count,
  input  logic [NUM_CH-1:0]       ch_enable,
  input  logic [NUM_CH*CNT_W-1:0] ch_phase_shift,
  input  logic [NUM_CH*CNT_W-1:0] ch_trigger_len,
  output logic [NUM_CH-1:0]       output_trigger,
  output logic                    busy,
  output logic                    done,
  output logic                    timeout_err,
  output logic [BURST_W-1:0]      burst_index,
  output logic [7:0]              scenario_state
);

  typedef enum logic [2:0] {
    S_IDLE             = 3'd0,
    S_FG_WAIT_OPTO     = 3'd1,
    S_FG_WAIT_OPEN     = 3'd2,
    S_WAIT_PHASE_FRONT = 3'd3,
    S_FIRE             = 3'd4,
    S_DONE             = 3'd5
  } state_t;

  localparam int NIN      = 4;
  localparam int IN_START = 0;
  localparam int IN_ABORT = 1;
  localparam int IN_FG    = 2;
  localparam int IN_PHASE = 3;

  state_t                          state;
  logic [NIN-1:0]                  raw_in;
  logic [NIN-1:0][SYNC_STAGES-1:0] sync_q;
  logic [NIN-1:0]                  sync_last;
  logic [NIN-1:0]                  prev_q;
  logic [NIN-1:0]                  edge_flag;
  logic [SYNC_STAGES:0]            ready_q;

  // Scenario parameters captured when a start is accepted.
  logic [CNT_W-1:0]        delay_q;
  logic [CNT_W-1:0]        timeout_q;
  logic [BURST_W-1:0]      burst_q;
  logic [NUM_CH-1:0]       en_q;
  logic [NUM_CH*CNT_W-1:0] shift_q;
  logic [NUM_CH*CNT_W-1:0] len_q;

  logic [CNT_W-1:0]   wait_cnt;
  logic [CNT_W-1:0]   wait_inc;
  logic [CNT_W:0]     elapsed;
  logic [CNT_W:0]     elapsed_inc;
  logic [CNT_W:0]     fire_time;
  logic [BURST_W-1:0] burst_next;
  logic               timeout_hit;
  logic               open_done;
  logic [NUM_CH-1:0]  ch_active;
  logic [NUM_CH-1:0]  ch_finished;
  logic [NUM_CH-1:0]  trig_next;
  logic               all_finished;

  assign raw_in = {phase_signal, fg_signal, abort_signal, start_signal};

  // Input synchronizers, one-flop edge history, and a blanking shift register
  // that hides the synchronizer fill after reset so a level already high at
  // release is not mistaken for an edge.
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      sync_q  <= '0;
      prev_q  <= '0;
      ready_q <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples pre-edge values regardless of statement order.
      for (int i = 0; i < NIN; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], raw_in[i]};
      end
      prev_q  <= sync_last;
      ready_q <= {ready_q[SYNC_STAGES-1:0], 1'b1};
    end
  end

  // Pick the last synchronizer stage of every input.
  always_comb begin
    // NOTE: a default assignment first keeps combinational blocks latch-free.
    sync_last = '0;
    for (int i = 0; i < NIN; i++) begin
      sync_last[i] = sync_q[i][SYNC_STAGES-1];
    end
  end

  assign edge_flag = sync_last & ~prev_q & {NIN{ready_q[SYNC_STAGES]}};

  // Saturating increments and wait-state compares.
  assign wait_inc    = (wait_cnt == '1) ? wait_cnt : wait_cnt + CNT_W'(1);
  assign elapsed_inc = (elapsed == '1) ? elapsed : elapsed + (CNT_W+1)'(1);
  assign burst_next  = (burst_index == '1) ? burst_index : burst_index + BURST_W'(1);
  assign open_done   = (wait_cnt >= delay_q);
  assign timeout_hit = (timeout_q != '0) &&
                       (({1'b0, wait_cnt} + (CNT_W+1)'(1)) >= {1'b0, timeout_q});

  // Cycles since the accepted phase edge; zero while still waiting so the
  // first output cycle after the edge can already be high for a zero shift.
  assign fire_time = (state == S_FIRE) ? elapsed : '0;

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    logic [CNT_W:0] shift_e;
    logic [CNT_W:0] end_e;
    assign shift_e        = {1'b0, shift_q[g*CNT_W +: CNT_W]};
    assign end_e          = shift_e + {1'b0, len_q[g*CNT_W +: CNT_W]};
    assign ch_active[g]   = en_q[g] && (len_q[g*CNT_W +: CNT_W] != '0);
    assign ch_finished[g] = !ch_active[g] || (fire_time > end_e);
    assign trig_next[g]   = ch_active[g] && (fire_time >= shift_e) && (fire_time < end_e);
  end

  assign all_finished = &ch_finished;

  // Scenario sequencer with registered trigger, done and status outputs.
  always_ff @(posedge clock or negedge reset_signal) begin
    if (!reset_signal) begin
      state          <= S_IDLE;
      output_trigger <= '0;
      done           <= 1'b0;
      timeout_err    <= 1'b0;
      burst_index    <= '0;
      wait_cnt       <= '0;
      elapsed        <= '0;
      delay_q        <= '0;
      timeout_q      <= '0;
      burst_q        <= '0;
      en_q           <= '0;
      shift_q        <= '0;
      len_q          <= '0;
    end else begin
      done           <= 1'b0;
      output_trigger <= '0;
      if (edge_flag[IN_ABORT] && state != S_IDLE) begin
        state <= S_IDLE;
      end else begin
        case (state)
          S_IDLE: begin
            if (edge_flag[IN_START]) begin
              delay_q     <= fg_open_delay;
              timeout_q   <= fg_timeout;
              burst_q     <= (burst_count == '0) ? BURST_W'(1) : burst_count;
              en_q        <= ch_enable;
              shift_q     <= ch_phase_shift;
              len_q       <= ch_trigger_len;
              burst_index <= '0;
              timeout_err <= 1'b0;
              wait_cnt    <= '0;
              state       <= S_FG_WAIT_OPTO;
            end
          end
          S_FG_WAIT_OPTO: begin
            if (edge_flag[IN_FG]) begin
              wait_cnt <= '0;
              state    <= S_FG_WAIT_OPEN;
            end else if (timeout_hit) begin
              timeout_err <= 1'b1;
              state       <= S_IDLE;
            end else begin
              wait_cnt <= wait_inc;
            end
          end
          S_FG_WAIT_OPEN: begin
            if (open_done) begin
              wait_cnt <= '0;
              state    <= S_WAIT_PHASE_FRONT;
            end else begin
              wait_cnt <= wait_inc;
            end
          end
          S_WAIT_PHASE_FRONT: begin
            if (edge_flag[IN_PHASE]) begin
              elapsed        <= (CNT_W+1)'(1);
              output_trigger <= trig_next;
              state          <= S_FIRE;
            end else if (timeout_hit) begin
              timeout_err <= 1'b1;
              state       <= S_IDLE;
            end else begin
              wait_cnt <= wait_inc;
            end
          end
          S_FIRE: begin
            if (all_finished) begin
              burst_index <= burst_next;
              wait_cnt    <= '0;
              if (burst_next < burst_q) begin
                state <= S_WAIT_PHASE_FRONT;
              end else begin
                done  <= 1'b1;
                state <= S_DONE;
              end
            end else begin
              output_trigger <= trig_next;
              elapsed        <= elapsed_inc;
            end
          end
          S_DONE:  state <= S_IDLE;
          default: state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy           = (state != S_IDLE);
  assign scenario_state = {5'd0, state};

endmodule
